// File: rtl/wb_pkg.sv
// Writeback arbiter shared types.
// One register-file write request: destination and value.
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests.
// Push when full and pop when empty are ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  wb_req_t       din_i,
  input  logic          pop_i,
  output wb_req_t       dout_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ?
      '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = nxt(wptr_q);
    if (do_pop)  rptr_d = nxt(rptr_q);
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline (A) vs buffered
// long-latency results (B), with a starvation-forced B grant.
module wb_arbiter #(
  parameter  int XLEN         = 32,
  parameter  int REG_AW       = 5,
  parameter  int B_DEPTH      = 2,
  parameter  int STARVE_LIMIT = 4,
  localparam int CW = $clog2(B_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [XLEN-1:0]   a_data,
  output logic              a_stall,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [XLEN-1:0]   b_data,
  output logic [CW-1:0]     b_count,
  output logic              we,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   rd_data
);
  import wb_pkg::*;

  localparam int WW = $clog2(STARVE_LIMIT + 1);

  wb_req_t           b_req, head;
  logic              push, pop, empty, full;
  logic              a_live, forced;
  logic              sel_f, sel_a, sel_b;
  logic [WW-1:0]     wait_q, wait_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;

  assign b_req.rd   = b_rd;
  assign b_req.data = b_data;

  wb_fifo #(
    .DEPTH (B_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (b_req),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (b_count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign b_ready = rst_n && !full;
  // x0 transfers complete the handshake but never enter the FIFO.
  assign push    = b_valid && b_ready && (b_rd != '0);
  assign a_live  = a_valid && (a_rd != '0);
  assign forced  = !empty &&
                   (wait_q == WW'(STARVE_LIMIT));
  assign a_stall = forced;

  assign sel_f = forced;
  assign sel_a = !forced && a_live;
  assign sel_b = !forced && !a_live && !empty;

  always_comb begin
    pop    = 1'b0;
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    unique case (1'b1)
      sel_f, sel_b: begin
        pop    = 1'b1;
        we_d   = 1'b1;
        rd_d   = head.rd;
        data_d = head.data;
      end
      sel_a: begin
        we_d   = 1'b1;
        rd_d   = a_rd;
        data_d = a_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (pop || empty)
      wait_d = '0;
    else if (wait_q != WW'(STARVE_LIMIT))
      wait_d = wait_q + WW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wait_q <= wait_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign we      = we_q;
  assign rd      = rd_q;
  assign rd_data = data_q;

endmodule
